jk_bank_arbiter: RTL and testbench

JK_BANK_ARBITER -- requirements
Module: jk_bank_arbiter

---
 rtl/jk_arb_pkg.sv | 31 +++
 rtl/jk_bank_arbiter_rr_pick.sv | 28 ++
 rtl/jk_bank_arbiter.sv | 124 ++++++++++++
 tb/tb_jk_bank_arbiter.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/jk_arb_pkg.sv
// Shared types for the JK bank arbiter: FSM states, JK op codes
// and the per-bit JK next-state function.
package jk_arb_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      APPLY   = 2'd1,
      HOLD_ST = 2'd2
   } state_t;

   typedef enum logic [1:0] {
      OP_HOLD = 2'b00,
      OP_CLR  = 2'b01,
      OP_SET  = 2'b10,
      OP_TOG  = 2'b11
   } jk_op_t;

   function automatic logic jk_next(input logic j, input logic k,
                                    input logic q);
      jk_op_t op;
      op = jk_op_t'({j, k});
      case (op)
         OP_HOLD: return q;
         OP_CLR:  return 1'b0;
         OP_SET:  return 1'b1;
         OP_TOG:  return ~q;
         default: return q;
      endcase
   endfunction

endpackage

// File: rtl/jk_bank_arbiter_rr_pick.sv
// Combinational round-robin selector: first set req bit after ptr,
// wrapping modulo NREQ.
module rr_pick #(
   parameter int NREQ = 4,
   parameter int PW   = $clog2(NREQ)
) (
   input  logic [NREQ-1:0] req,
   input  logic [PW-1:0]   ptr,
   output logic [NREQ-1:0] winner,
   output logic            valid
);

   logic [PW-1:0] idx;

   always_comb begin
      winner = '0;
      valid  = 1'b0;
      idx    = '0;
      for (int i = 1; i <= NREQ; i++) begin
         idx = PW'((int'(ptr) + i) % NREQ);
         if (!valid && req[idx]) begin
            winner[idx] = 1'b1;
            valid       = 1'b1;
         end
      end
   end

endmodule

// File: rtl/jk_bank_arbiter.sv
// Round-robin arbiter applying one JK command per round to a shared bank.
// Optional JK_ARB_STATS_EN adds per-requester saturating grant counters.
module jk_bank_arbiter
   import jk_arb_pkg::*;
#(
   parameter int NREQ  = 4,
   parameter int WIDTH = 8,
   parameter int HOLD  = 1
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [NREQ-1:0]       req,
   input  logic [NREQ*WIDTH-1:0] j_in,
   input  logic [NREQ*WIDTH-1:0] k_in,
   output logic [NREQ-1:0]       ack,
   output logic [NREQ-1:0]       gnt,
   output logic                  busy,
   output logic [WIDTH-1:0]      q
`ifdef JK_ARB_STATS_EN
   ,
   output logic [NREQ*8-1:0]     grant_cnt
`endif
);

   localparam int PW = $clog2(NREQ);
   localparam logic [3:0] HCNT_INIT = (HOLD > 0) ? 4'(HOLD - 1) : 4'd0;

   state_t           state, state_n;
   logic [NREQ-1:0]  win;
   logic             win_vld;
   logic [PW-1:0]    ptr, win_idx, own_idx;
   logic [WIDTH-1:0] jc, kc, jq, kq, q_n;
   logic [3:0]       hcnt;

   rr_pick #(.NREQ(NREQ), .PW(PW)) u_pick (
      .req    (req),
      .ptr    (ptr),
      .winner (win),
      .valid  (win_vld)
   );

   always_comb begin
      jc      = '0;
      kc      = '0;
      win_idx = '0;
      for (int i = 0; i < NREQ; i++) begin
         if (win[i]) begin
            jc      = j_in[i*WIDTH +: WIDTH];
            kc      = k_in[i*WIDTH +: WIDTH];
            win_idx = PW'(i);
         end
      end
   end

   for (genvar b = 0; b < WIDTH; b++) begin : g_jk
      assign q_n[b] = jk_next(jq[b], kq[b], q[b]);
   end

   always_comb begin
      state_n = state;
      unique case (state)
         IDLE:    if (win_vld) state_n = APPLY;
         APPLY:   state_n = (HOLD > 0) ? HOLD_ST : IDLE;
         HOLD_ST: if (hcnt == 4'd0) state_n = IDLE;
         default: state_n = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state   <= IDLE;
         q       <= '0;
         ack     <= '0;
         gnt     <= '0;
         ptr     <= PW'(NREQ - 1);
         jq      <= '0;
         kq      <= '0;
         own_idx <= '0;
         hcnt    <= '0;
      end else begin
         state <= state_n;
         ack   <= '0;
         unique case (state)
            IDLE: begin
               if (win_vld) begin
                  // ack is registered so it lands exactly in the APPLY cycle
                  gnt     <= win;
                  ack     <= win;
                  jq      <= jc;
                  kq      <= kc;
                  own_idx <= win_idx;
               end else begin
                  gnt <= '0;
               end
            end
            APPLY: begin
               q    <= q_n;
               ptr  <= own_idx;
               hcnt <= HCNT_INIT;
               if (HOLD == 0) gnt <= '0;
            end
            HOLD_ST: begin
               if (hcnt == 4'd0) gnt <= '0;
               else hcnt <= hcnt - 4'd1;
            end
            default: gnt <= '0;
         endcase
      end
   end

   assign busy = (state != IDLE);

`ifdef JK_ARB_STATS_EN
   for (genvar i = 0; i < NREQ; i++) begin : g_cnt
      logic [7:0] cnt;
      always_ff @(posedge clk) begin
         if (reset) cnt <= '0;
         else if (ack[i] && cnt != 8'hFF) cnt <= cnt + 8'd1;
      end
      assign grant_cnt[i*8 +: 8] = cnt;
   end
`endif

endmodule

// File: tb/tb_jk_bank_arbiter.sv
// Scoreboard bench for jk_bank_arbiter: random rounds checked against
// a rotation/JK-rule model; monitor pops expectations on each ack.
module tb_jk_bank_arbiter;

   localparam int NREQ  = 4;
   localparam int WIDTH = 8;
   localparam int HOLD  = 1;

   logic                  clk = 1'b0;
   logic                  reset;
   logic [NREQ-1:0]       req;
   logic [NREQ*WIDTH-1:0] j_in, k_in;
   logic [NREQ-1:0]       ack, gnt;
   logic                  busy;
   logic [WIDTH-1:0]      q;
`ifdef JK_ARB_STATS_EN
   logic [NREQ*8-1:0]     grant_cnt;
`endif

   jk_bank_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH), .HOLD(HOLD)) dut (
      .clk   (clk),
      .reset (reset),
      .req   (req),
      .j_in  (j_in),
      .k_in  (k_in),
      .ack   (ack),
      .gnt   (gnt),
      .busy  (busy),
      .q     (q)
`ifdef JK_ARB_STATS_EN
      ,
      .grant_cnt (grant_cnt)
`endif
   );

   always #5 clk = ~clk;

   typedef struct {
      int               idx;
      logic [WIDTH-1:0] qv;
      int               rnd;
   } exp_t;

   exp_t             sb[$];
   int               checks = 0;
   int               errors = 0;
   int               m_ptr;
   logic [WIDTH-1:0] m_q;
   int               round_no = 0;
   logic             ignore_ack = 1'b0;

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h expected=%0h t=%0t",
                  name, act, exp, $time);
      end
   endtask

   // Expected service order: requesters in set, in rotation from m_ptr+1.
   task automatic run_round(input logic [NREQ-1:0] set, input bit scramble);
      int n;
      int last;
      logic [WIDTH-1:0] jv, kv;
      round_no++;
      last = m_ptr;
      for (int s = 1; s <= NREQ; s++) begin
         int idx;
         idx = (m_ptr + s) % NREQ;
         if (set[idx]) begin
            exp_t e;
            jv   = j_in[idx*WIDTH +: WIDTH];
            kv   = k_in[idx*WIDTH +: WIDTH];
            m_q  = (jv & ~m_q) | (~kv & m_q);
            e.idx = idx;
            e.qv  = m_q;
            e.rnd = round_no;
            sb.push_back(e);
            last = idx;
         end
      end
      m_ptr = last;
      req = set;
      n = 0;
      while (req != '0 && n < 200) begin
         @(negedge clk);
         n++;
         for (int i = 0; i < NREQ; i++) begin
            if (ack[i]) begin
               req[i] = 1'b0;
               if (scramble) begin
                  j_in[i*WIDTH +: WIDTH] = WIDTH'($urandom);
                  k_in[i*WIDTH +: WIDTH] = WIDTH'($urandom);
               end
            end
         end
      end
      chk("round_done", 32'(req), 32'd0);
      repeat (HOLD + 3) @(negedge clk);
   endtask

   task automatic rand_data();
      for (int i = 0; i < NREQ; i++) begin
         j_in[i*WIDTH +: WIDTH] = WIDTH'($urandom);
         k_in[i*WIDTH +: WIDTH] = WIDTH'($urandom);
      end
   endtask

   // Monitor
   initial begin
      int               cyc;
      int               last_cyc;
      int               last_rnd;
      logic             qpend;
      logic [WIDTH-1:0] qexp;
      exp_t             e;
      cyc = 0;
      last_cyc = -100;
      last_rnd = -1;
      qpend = 1'b0;
      qexp = '0;
      forever begin
         @(negedge clk);
         cyc++;
         if (qpend) begin
            chk("q_after_apply", 32'(q), 32'(qexp));
            qpend = 1'b0;
         end
         chk("gnt_onehot", 32'($countones(gnt) <= 1), 32'd1);
         chk("ack_onehot", 32'($countones(ack) <= 1), 32'd1);
         if (ack != '0 && !ignore_ack) begin
            if (sb.size() == 0) begin
               chk("unexpected_ack", 32'(ack), 32'd0);
            end else begin
               e = sb.pop_front();
               chk("ack", 32'(ack), 32'(1) << e.idx);
               chk("gnt", 32'(gnt), 32'(1) << e.idx);
               chk("busy_apply", 32'(busy), 32'd1);
               if (e.rnd == last_rnd)
                  chk("ack_gap", 32'(cyc - last_cyc), 32'(HOLD + 2));
               last_rnd = e.rnd;
               last_cyc = cyc;
               qexp  = e.qv;
               qpend = 1'b1;
            end
         end
      end
   end

   // Driver
   initial begin
      reset = 1'b1;
      req   = '0;
      j_in  = '0;
      k_in  = '0;
      m_ptr = NREQ - 1;
      m_q   = '0;
      repeat (2) @(negedge clk);
      chk("rst_q", 32'(q), 32'd0);
      chk("rst_ack", 32'(ack), 32'd0);
      chk("rst_gnt", 32'(gnt), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      reset = 1'b0;
      @(negedge clk);

      j_in[7:0] = 8'hF0;
      k_in[7:0] = 8'h00;
      run_round(4'b0001, 1'b1);
      chk("first_q", 32'(q), 32'hF0);

      j_in[23:16] = 8'hFF;
      k_in[23:16] = 8'h0F;
      run_round(4'b0100, 1'b0);
      chk("set_toggle_q", 32'(q), 32'hFF);
      j_in[23:16] = 8'h00;
      k_in[23:16] = 8'hFF;
      run_round(4'b0100, 1'b0);
      chk("clear_q", 32'(q), 32'h00);

      rand_data();
      run_round(4'b1111, 1'b1);
      repeat (20) begin
         rand_data();
         run_round(NREQ'($urandom_range(1, (1 << NREQ) - 1)), 1'b1);
      end

      // Reset while a command sits in APPLY
      j_in[31:24] = 8'hA5;
      k_in[31:24] = 8'h00;
      run_round(4'b1000, 1'b0);
      ignore_ack = 1'b1;
      j_in[7:0] = 8'h0F;
      k_in[7:0] = 8'hF0;
      req = 4'b0001;
      @(posedge clk);
      #1;
      chk("probe_busy", 32'(busy), 32'd1);
      req   = '0;
      reset = 1'b1;
      @(posedge clk);
      #1;
      reset = 1'b0;
      chk("midrst_q", 32'(q), 32'd0);
      chk("midrst_busy", 32'(busy), 32'd0);
      chk("midrst_ack", 32'(ack), 32'd0);
      chk("midrst_gnt", 32'(gnt), 32'd0);
      @(negedge clk);
      ignore_ack = 1'b0;
      m_ptr = NREQ - 1;
      m_q   = '0;

      rand_data();
      run_round(4'b1111, 1'b1);
      rand_data();
      run_round(4'b1111, 1'b1);

`ifdef JK_ARB_STATS_EN
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      m_ptr = NREQ - 1;
      m_q   = '0;
      repeat (300) begin
         rand_data();
         run_round(4'b0010, 1'b1);
      end
      for (int i = 0; i < NREQ; i++)
         chk("grant_cnt", 32'(grant_cnt[i*8 +: 8]), (i == 1) ? 32'd255 : 32'd0);
`endif

      chk("sb_empty", 32'(sb.size()), 32'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
